self_memory: RTL and testbench



---
 rtl/self_memory_pkg.sv | 8 +
 rtl/self_memory_addsub.sv | 26 ++
 rtl/self_memory.sv | 34 +++
 tb/tb_self_memory.sv | 94 +++++++++
 4 files changed

// File: rtl/self_memory_pkg.sv
// self_memory_pkg: shared width, op encoding and saturation limits for self_memory
package self_memory_pkg;
  localparam int WIDTH = 8;
  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
endpackage

// File: rtl/self_memory_addsub.sv
// self_memory_addsub: combinational two's-complement add/sub with signed overflow (saturates under SELF_MEMORY_SAT_EN)
module self_memory_addsub
  import self_memory_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         add_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] nxt_result,
  output logic         nxt_ovf
);
  logic [W-1:0] bx, s, sat;
  // subtract as a + ~b + 1; overflow when operand signs agree but the sum sign differs
  always_comb begin
    bx = (add_sub == OP_ADD) ? b : ~b;
    s = a + bx + W'(add_sub == OP_SUB);
    nxt_ovf = (a[W-1] == bx[W-1]) && (s[W-1] != a[W-1]);
    sat = {a[W-1], {(W-1){~a[W-1]}}};
`ifdef SELF_MEMORY_SAT_EN
    nxt_result = nxt_ovf ? sat : s;
`else
    nxt_result = s;
`endif
  end
endmodule

// File: rtl/self_memory.sv
// self_memory: registered adder/subtractor holding its last result; optional saturation via SELF_MEMORY_SAT_EN
module self_memory
  import self_memory_pkg::*;
#(
  parameter int WIDTH = self_memory_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             add_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_ovf;
  self_memory_addsub #(.W(WIDTH)) u_addsub (
    .add_sub   (add_sub),
    .a         (a),
    .b         (b),
    .nxt_result(nxt_result),
    .nxt_ovf   (nxt_ovf)
  );
  // result register, cleared asynchronously while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
      ovf <= 1'b0;
    end else begin
      result <= nxt_result;
      ovf <= nxt_ovf;
    end
  end
endmodule

// File: tb/tb_self_memory.sv
// tb_self_memory: scoreboard bench for self_memory
module tb_self_memory;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic add_sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [7:0] result;
  logic ovf;
  int total = 0, bad = 0;
  logic [8:0] q[$];
  logic [8:0] me;

  self_memory dut (
    .clk    (clk),
    .reset  (reset),
    .add_sub(add_sub),
    .a      (a),
    .b      (b),
    .result (result),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got ovf,result=%h want=%h", n, act, exp);
    end
  endtask

  task automatic drive(input logic op, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input logic eo);
    @(negedge clk);
    add_sub = op;
    a = x;
    b = y;
    q.push_back({eo, er});
  endtask

  always @(posedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      #1 check("edge", {ovf, result}, me);
    end
  end

  initial begin
    #12 check("rst_hold", {ovf, result}, 9'h000);
    @(negedge clk) reset = 1'b1;
    drive(1'b1, 8'd12, 8'd44, 8'h38, 1'b0);
`ifdef SELF_MEMORY_SAT_EN
    drive(1'b1, 8'h97, 8'hA2, 8'h80, 1'b1);
`else
    drive(1'b1, 8'h97, 8'hA2, 8'h39, 1'b1);
`endif
    drive(1'b0, 8'd35, 8'd13, 8'h16, 1'b0);
    drive(1'b0, 8'd20, 8'd56, 8'hDC, 1'b0);
`ifdef SELF_MEMORY_SAT_EN
    drive(1'b0, 8'h80, 8'h01, 8'h80, 1'b1);
    drive(1'b1, 8'h7F, 8'h01, 8'h7F, 1'b1);
    drive(1'b0, 8'h7F, 8'hFF, 8'h7F, 1'b1);
    drive(1'b0, 8'h00, 8'h80, 8'h7F, 1'b1);
`else
    drive(1'b0, 8'h80, 8'h01, 8'h7F, 1'b1);
    drive(1'b1, 8'h7F, 8'h01, 8'h80, 1'b1);
    drive(1'b0, 8'h7F, 8'hFF, 8'h80, 1'b1);
    drive(1'b0, 8'h00, 8'h80, 8'h80, 1'b1);
`endif
    drive(1'b1, 8'hFF, 8'h01, 8'h00, 1'b0);
    drive(1'b0, 8'h05, 8'h05, 8'h00, 1'b0);
    drive(1'b1, 8'h80, 8'h7F, 8'hFF, 1'b0);
    drive(1'b1, 8'd5, 8'd6, 8'h0B, 1'b0);
    @(posedge clk);
    #2 add_sub = 1'b0;
    a = 8'd100;
    b = 8'd100;
    #2 check("hold_between_edges", {ovf, result}, 9'h00B);
    drive(1'b1, 8'd3, 8'd4, 8'h07, 1'b0);
    drive(1'b1, 8'h10, 8'h20, 8'h30, 1'b0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check("async_rst", {ovf, result}, 9'h000);
    @(posedge clk);
    #1 check("rst_hold_edge", {ovf, result}, 9'h000);
    @(negedge clk) reset = 1'b1;
    drive(1'b1, 8'd1, 8'd1, 8'h02, 1'b0);
    repeat (3) @(posedge clk);
    #2 check("drain", 9'(q.size()), 9'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
